// File: rtl/img_copy_seq.sv
// img_copy_seq: per-pixel read/optional-invert/write sequencer driving an AHB master command port
module img_copy_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [11:0] image_width,
  input  logic [11:0] image_height,
  input  logic        data_feedback,
  input  logic [31:0] rdata,
  input  logic        error,
  output logic [1:0]  mode,
  output logic [19:0] pixNum,
  output logic        startAddr_sel,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err_flag
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDR  = 3'd1;
  localparam logic [2:0] S_RDC  = 3'd2;
  localparam logic [2:0] S_WRR  = 3'd3;
  localparam logic [2:0] S_WRF  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_FAIL = 3'd6;
  localparam logic [7:0] TMO    = TIMEOUT[7:0];
  localparam logic [23:0] MAX_PIX = 24'd1048576;

  logic [2:0]  state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [19:0] pix_q, pix_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] total_q, total_d, total_in;
  logic        op_q, op_d, err_q, err_d;
  logic        req, last;

  assign total_in = image_width * image_height;
  assign req      = (state_q == S_RDR) || (state_q == S_WRR);
  assign last     = {4'd0, pix_q} == total_q - 24'd1;

  // Moore outputs decoded from the state register plus held data registers
  assign mode          = state_q == S_RDR ? 2'b01 : state_q == S_WRR ? 2'b10 : 2'b00;
  assign startAddr_sel = (state_q == S_WRR) || (state_q == S_WRF);
  assign busy          = req || (state_q == S_RDC) || (state_q == S_WRF);
  assign done          = (state_q == S_DONE) || (state_q == S_FAIL);
  assign pixNum        = pix_q;
  assign wdata         = wdata_q;
  assign err_flag      = err_q;

  // next-state logic; error beats data_feedback, timeout only when no strobe is present
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    wdata_d = wdata_q;
    total_d = total_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d    = op;
        total_d = total_in;
        err_d   = 1'b0;
        pix_d   = '0;
        state_d = total_in == '0 ? S_DONE : total_in > MAX_PIX ? S_FAIL : S_RDR;
      end
      S_RDR:  state_d = error ? S_FAIL : data_feedback ? S_RDC : tmo_q == TMO ? S_FAIL : S_RDR;
      S_RDC: begin
        wdata_d = op_q ? ~rdata : rdata;
        state_d = S_WRR;
      end
      S_WRR:  state_d = error ? S_FAIL : data_feedback ? S_WRF : tmo_q == TMO ? S_FAIL : S_WRR;
      S_WRF: begin
        state_d = last ? S_DONE : S_RDR;
        pix_d   = last ? pix_q : pix_q + 20'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FAIL) err_d = 1'b1;
    tmo_d = (req && state_d == state_q) ? tmo_q + 8'd1 : 8'd0;
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      pix_q   <= '0;
      wdata_q <= '0;
      total_q <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      pix_q   <= pix_d;
      wdata_q <= wdata_d;
      total_q <= total_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_img_copy_seq.sv
// tb_img_copy_seq: directed bench with a zero-wait master/slave model and write scoreboard
module tb_img_copy_seq;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
  logic [11:0] image_width = '0, image_height = '0;
  logic        data_feedback = 1'b0, error = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  mode;
  logic [19:0] pixNum;
  logic        startAddr_sel;
  logic [31:0] wdata;
  logic        busy, done, err_flag;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] mem [16];
  logic [51:0] exp_q [$];
  logic [1:0]  modes [$];
  logic [51:0] e;
  logic [31:0] rd_word;
  logic [1:0]  kind;
  logic [15:0] ms;
  int ph = 0, wcnt = 0, xfers = 0, x0 = 0, rd_wait_pix = -1, rd_waits = 0, err_pix = -1, lat = 0;
  bit noresp = 0, sb_en = 1;
  logic e1;

  img_copy_seq #(.TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .image_width(image_width), .image_height(image_height),
    .data_feedback(data_feedback), .rdata(rdata), .error(error),
    .mode(mode), .pixNum(pixNum), .startAddr_sel(startAddr_sel), .wdata(wdata),
    .busy(busy), .done(done), .err_flag(err_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // master model: command seen in cycle c, strobe in c+2 (+waits), read data in c+3
  always @(negedge clk) begin
    if (rst) begin
      ph = 0;
      data_feedback = 1'b0;
      error = 1'b0;
    end else begin
      case (ph)
        0: if (mode != 2'b00) begin
          kind = mode;
          wcnt = (mode == 2'b01 && int'(pixNum) == rd_wait_pix) ? rd_waits : 0;
          xfers++;
          check("sel", 64'(startAddr_sel), 64'(mode == 2'b10));
          ph = 1;
        end
        1: if (!noresp) begin
          if (wcnt > 0) wcnt--;
          else ph = 2;
        end
        2: begin
          if (kind == 2'b10 && int'(pixNum) == err_pix) error = 1'b1;
          else begin
            data_feedback = 1'b1;
            if (kind == 2'b01) rd_word = mem[pixNum[3:0]];
            else if (sb_en) begin
              check("wr_expected", 64'(exp_q.size() != 0), 64'(1));
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_pix", 64'(pixNum), 64'(e[51:32]));
                check("wr_data", 64'(wdata), 64'(e[31:0]));
              end
            end
          end
          ph = 3;
        end
        default: begin
          if (kind == 2'b01) rdata = rd_word;
          data_feedback = 1'b0;
          error = 1'b0;
          ph = 0;
        end
      endcase
    end
  end

  task automatic run_job(input int w, input int h, input bit o, input int restart,
                         output int lt, output logic ef);
    int t0;
    image_width = 12'(w);
    image_height = 12'(h);
    op = o;
    start = 1'b1;
    t0 = cyc;
    lt = -1;
    ef = 1'bx;
    modes.delete();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      modes.push_back(mode);
      if (k == 0) ef = err_flag;
      if (restart > 0 && k == restart) begin
        start = 1'b1;
        image_width = 12'd5;
        image_height = 12'd5;
        op = ~o;
      end else start = 1'b0;
      if (done) begin
        lt = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("job_completed", 64'(lt >= 0), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({mode, pixNum, startAddr_sel, wdata, busy, done, err_flag}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 0; i < 4; i++) exp_q.push_back({20'(i), mem[i]});
    run_job(2, 2, 1'b0, 0, lat, e1);
    check("copy_lat", 64'(lat), 64'(33));
    check("copy_err", 64'(err_flag), 64'(0));
    check("copy_pix", 64'(pixNum), 64'(3));
    check("copy_sb_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      mem[i] = 32'h0000FFFF;
      exp_q.push_back({20'(i), 32'hFFFF0000});
    end
    run_job(1, 3, 1'b1, 0, lat, e1);
    ms = '0;
    for (int i = 0; i < 8; i++) ms = {ms[13:0], modes[i]};
    check("inv_mode_seq", 64'(ms), 64'(16'b01_01_01_00_10_10_10_00));
    check("inv_lat", 64'(lat), 64'(25));
    check("inv_busy_at_done", 64'(busy), 64'(0));
    check("inv_sb_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);

    rd_wait_pix = 1; rd_waits = 3;
    mem[0] = 32'hA1; mem[1] = 32'hB2; mem[2] = 32'hC3;
    for (int i = 0; i < 3; i++) exp_q.push_back({20'(i), mem[i]});
    run_job(3, 1, 1'b0, 0, lat, e1);
    check("wait_lat", 64'(lat), 64'(28));
    check("wait_err", 64'(err_flag), 64'(0));
    check("wait_sb_empty", 64'(exp_q.size()), 64'(0));
    rd_wait_pix = -1;
    @(negedge clk);

    err_pix = 2;
    for (int i = 0; i < 4; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    for (int i = 0; i < 2; i++) exp_q.push_back({20'(i), mem[i]});
    run_job(4, 1, 1'b0, 0, lat, e1);
    check("buserr_lat", 64'(lat), 64'(24));
    check("buserr_flag", 64'(err_flag), 64'(1));
    check("buserr_pix", 64'(pixNum), 64'(2));
    check("buserr_mode", 64'(mode), 64'(0));
    check("buserr_sb_empty", 64'(exp_q.size()), 64'(0));
    err_pix = -1;
    @(negedge clk);
    check("flag_sticky_idle", 64'(err_flag), 64'(1));

    mem[0] = 32'h5A5A5A5A;
    exp_q.push_back({20'd0, mem[0]});
    run_job(1, 1, 1'b0, 0, lat, e1);
    check("restart_clears_err", 64'(e1), 64'(0));
    check("restart_lat", 64'(lat), 64'(9));
    check("restart_sb_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);

    mem[0] = 32'h01234567; mem[1] = 32'h89ABCDEF;
    for (int i = 0; i < 2; i++) exp_q.push_back({20'(i), mem[i]});
    run_job(1, 2, 1'b0, 3, lat, e1);
    check("busy_start_ignored_lat", 64'(lat), 64'(17));
    check("busy_start_sb_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);

    noresp = 1;
    run_job(1, 1, 1'b0, 0, lat, e1);
    check("timeout_lat", 64'(lat), 64'(12));
    check("timeout_err", 64'(err_flag), 64'(1));
    noresp = 0;
    repeat (4) @(negedge clk);

    x0 = xfers;
    run_job(0, 5, 1'b0, 0, lat, e1);
    check("zero_lat", 64'(lat), 64'(1));
    check("zero_err", 64'(err_flag), 64'(0));
    check("zero_mode", 64'(modes[0]), 64'(0));
    check("zero_no_bus", 64'(xfers - x0), 64'(0));
    @(negedge clk);

    run_job(2048, 1024, 1'b0, 0, lat, e1);
    check("oversize_lat", 64'(lat), 64'(1));
    check("oversize_err", 64'(err_flag), 64'(1));
    @(negedge clk);

    sb_en = 0;
    image_width = 12'd4; image_height = 12'd4; op = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && mode != 2'b10; k++) @(negedge clk);
    check("reached_write", 64'(mode), 64'(2));
    rst = 1'b1;
    @(negedge clk);
    check("midjob_rst_outputs", 64'({mode, pixNum, startAddr_sel, wdata, busy, done, err_flag}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 64'({mode, busy}), 64'(0));
    sb_en = 1;

    mem[0] = 32'hFEEDBEEF;
    exp_q.push_back({20'd0, mem[0]});
    run_job(1, 1, 1'b0, 0, lat, e1);
    check("recover_lat", 64'(lat), 64'(9));
    check("recover_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
